assay_sequencer: RTL and testbench

Digital controller for the 12-channel in-vitro diagnostic array (paired-inlet mixer feeding a per-channel fluorescence detector). It runs one channel at a time. For each channel it opens inlet A, then inlet B, waits for mixing, integrates the channel's detector flag over a read window, and reports one pass/fail bit over a valid/ready stream. It drives the 24 inlet valves and consumes the 12 detector flags, so it is the control and readout end of the array.

---
 rtl/assay_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_assay_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assay_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : assay_sequencer
// Description : Per-channel inlet A / inlet B / mix / read / report sequencer
//               for the paired-inlet diagnostic array. Drives the inlet
//               valves, integrates each channel's detector flag over a fixed
//               window and streams one pass/fail bit per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module assay_sequencer #(
    parameter  int N_CH        = 12,
    parameter  int READ_CYCLES = 16,
    parameter  int READ_THRESH = 8,
    localparam int CHW         = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int RCW         = $clog2(READ_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [7:0]        disp_cycles_i,
    input  logic [15:0]       mix_cycles_i,
    input  logic [N_CH-1:0]   det_in_i,
    output logic [2*N_CH-1:0] valve_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CHW-1:0]    res_ch_o,
    output logic              res_val_o,
    output logic [N_CH-1:0]   result_vec_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DISP_A = 3'd1,
        S_DISP_B = 3'd2,
        S_MIX    = 3'd3,
        S_READ   = 3'd4,
        S_REPORT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [15:0]    READ_LOAD = 16'(READ_CYCLES - 1);
    localparam logic [RCW-1:0] RCNT_MAX  = RCW'(READ_CYCLES);
    localparam logic [RCW-1:0] RCNT_THR  = RCW'(READ_THRESH);
    localparam logic [CHW-1:0] CH_LAST   = CHW'(N_CH - 1);

    state_t              state_q, state_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic [15:0]         tmr_q, tmr_d;
    logic [7:0]          disp_q, disp_d;
    logic [15:0]         mix_q, mix_d;
    logic [RCW-1:0]      rcnt_q, rcnt_d;
    logic                res_val_q, res_val_d;
    logic [N_CH-1:0]     result_vec_q, result_vec_d;
    logic [2*N_CH-1:0]   valve_q, valve_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                res_valid_q, res_valid_d;

    logic                tmr_zero;
    logic [RCW-1:0]      rcnt_inc;

    // Timer reload for a dispense phase: a programmed zero still gives one cycle.
    function automatic logic [15:0] disp_load(input logic [7:0] d);
        return (d == 8'd0) ? 16'd0 : ({8'd0, d} - 16'd1);
    endfunction

    assign tmr_zero = (tmr_q == 16'd0);
    // Saturating high-sample count including this cycle's detector sample.
    assign rcnt_inc = (det_in_i[ch_q] && (rcnt_q != RCNT_MAX)) ? (rcnt_q + RCW'(1)) : rcnt_q;

    // Next-state logic; outputs are precomputed from the next state so they register cleanly.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        tmr_d        = tmr_q;
        disp_d       = disp_q;
        mix_d        = mix_q;
        rcnt_d       = rcnt_q;
        res_val_d    = res_val_q;
        result_vec_d = result_vec_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_DISP_A;
                    disp_d       = disp_cycles_i;
                    mix_d        = mix_cycles_i;
                    ch_d         = '0;
                    result_vec_d = '0;
                    tmr_d        = disp_load(disp_cycles_i);
                end
            end
            S_DISP_A: begin
                if (tmr_zero) begin
                    state_d = S_DISP_B;
                    tmr_d   = disp_load(disp_q);
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_DISP_B: begin
                if (tmr_zero) begin
                    if (mix_q == 16'd0) begin
                        state_d = S_READ;
                        tmr_d   = READ_LOAD;
                        rcnt_d  = '0;
                    end else begin
                        state_d = S_MIX;
                        tmr_d   = mix_q - 16'd1;
                    end
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_MIX: begin
                if (tmr_zero) begin
                    state_d = S_READ;
                    tmr_d   = READ_LOAD;
                    rcnt_d  = '0;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_READ: begin
                rcnt_d = rcnt_inc;
                if (tmr_zero) begin
                    state_d   = S_REPORT;
                    res_val_d = (rcnt_inc >= RCNT_THR);
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_REPORT: begin
                if (res_ready_i) begin
                    result_vec_d[ch_q] = res_val_q;
                    if (ch_q == CH_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DISP_A;
                        ch_d    = ch_q + CHW'(1);
                        tmr_d   = disp_load(disp_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a REPORT handshake in the same cycle.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            ch_d         = ch_q;
            result_vec_d = result_vec_q;
        end

        valve_d = '0;
        if (state_d == S_DISP_A) begin
            valve_d[{ch_d, 1'b0}] = 1'b1;
        end else if (state_d == S_DISP_B) begin
            valve_d[{ch_d, 1'b1}] = 1'b1;
        end
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        res_valid_d = (state_d == S_REPORT);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            tmr_q        <= '0;
            disp_q       <= '0;
            mix_q        <= '0;
            rcnt_q       <= '0;
            res_val_q    <= 1'b0;
            result_vec_q <= '0;
            valve_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            tmr_q        <= tmr_d;
            disp_q       <= disp_d;
            mix_q        <= mix_d;
            rcnt_q       <= rcnt_d;
            res_val_q    <= res_val_d;
            result_vec_q <= result_vec_d;
            valve_q      <= valve_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign valve_o      = valve_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign res_valid_o  = res_valid_q;
    assign res_ch_o     = ch_q;
    assign res_val_o    = res_val_q;
    assign result_vec_o = result_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_assay_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_assay_sequencer
// Description : Scoreboard bench for assay_sequencer. Expected results are
//               queued with their handshake cycle when a run is launched and
//               matched as the sequencer reports them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_assay_sequencer;

    localparam int N_CH = 12;
    localparam int CHW  = 4;
    localparam int RC   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              abort_i;
    logic [7:0]        disp_cycles_i;
    logic [15:0]       mix_cycles_i;
    logic [N_CH-1:0]   det_in_i;
    logic [2*N_CH-1:0] valve_o;
    logic              busy_o;
    logic              done_o;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [CHW-1:0]    res_ch_o;
    logic              res_val_o;
    logic [N_CH-1:0]   result_vec_o;

    typedef struct {
        int   ch;
        logic val;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    assay_sequencer #(.N_CH(N_CH), .READ_CYCLES(RC), .READ_THRESH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .disp_cycles_i (disp_cycles_i),
        .mix_cycles_i  (mix_cycles_i),
        .det_in_i      (det_in_i),
        .valve_o       (valve_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_ch_o      (res_ch_o),
        .res_val_o     (res_val_o),
        .result_vec_o  (result_vec_o)
    );

    always #5 clk = ~clk;

    // Queue the expected results of channels 0..n-1; ch0 carries val0.
    task automatic push_results(input int d, input int m, input int n, input logic val0,
                                input int stall_ch, input int stall_n);
        int   de, p, sh;
        exp_t e;
        de = (d == 0) ? 1 : d;
        p  = 2 * de + m + RC + 1;
        for (int k = 0; k < n; k++) begin
            sh    = (stall_ch >= 0 && k >= stall_ch) ? stall_n : 0;
            e.ch  = k;
            e.val = (k == 0) ? val0 : 1'b1;
            e.cyc = (k + 1) * p + sh;
            q.push_back(e);
        end
    endtask

    // Launch a run and step it cycle by cycle until busy drops; cycle 1 follows the start edge.
    task automatic run_seq(input int d, input int m, input int hi0, input int stall_ch,
                           input int stall_n, input int abort_cyc, input int spur_cyc,
                           output int done_cnt, output int done_cyc, output int end_cyc);
        int                de, p, sh, sk, rs0;
        logic [2*N_CH-1:0] ev;
        exp_t              e;
        de       = (d == 0) ? 1 : d;
        p        = 2 * de + m + RC + 1;
        rs0      = 2 * de + m + 1;
        done_cnt = 0;
        done_cyc = -1;
        end_cyc  = -1;
        disp_cycles_i = d[7:0];
        mix_cycles_i  = m[15:0];
        res_ready_i   = 1'b1;
        det_in_i      = '1;
        start_i       = 1'b1;
        @(posedge clk); #1;
        start_i       = 1'b0;
        // Change timing inputs mid-run; the captured values must be used.
        disp_cycles_i = 8'd77;
        mix_cycles_i  = 16'd3;
        for (int cyc = 1; cyc < 20000; cyc++) begin
            abort_i     = (cyc == abort_cyc);
            start_i     = (cyc == spur_cyc);
            res_ready_i = !(stall_ch >= 0 && cyc >= (stall_ch + 1) * p &&
                            cyc < (stall_ch + 1) * p + stall_n);
            det_in_i    = '1;
            if (hi0 >= 0)
                det_in_i[0] = (cyc >= rs0 && cyc < rs0 + hi0);

            ev = '0;
            if (abort_cyc < 0 || cyc <= abort_cyc) begin
                for (int k = 0; k < N_CH; k++) begin
                    sh = (stall_ch >= 0 && k > stall_ch) ? stall_n : 0;
                    sk = 1 + k * p + sh;
                    if (cyc >= sk && cyc < sk + de)
                        ev[2*k] = 1'b1;
                    else if (cyc >= sk + de && cyc < sk + 2 * de)
                        ev[2*k+1] = 1'b1;
                end
            end
            n_cmp++;
            if (valve_o !== ev) begin
                n_err++;
                $display("FAIL valve cyc=%0d got=%h exp=%h", cyc, valve_o, ev);
            end

            if (res_valid_o === 1'b1) begin
                if (!res_ready_i) begin
                    n_cmp++;
                    if (res_ch_o !== CHW'(stall_ch)) begin
                        n_err++;
                        $display("FAIL stall_ch cyc=%0d got=%0d exp=%0d", cyc, res_ch_o, stall_ch);
                    end
                end else if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result cyc=%0d got_ch=%0d exp=none", cyc, res_ch_o);
                end else begin
                    e = q.pop_front();
                    n_cmp++;
                    if (res_ch_o !== CHW'(e.ch) || res_val_o !== e.val || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL result got ch=%0d val=%0b cyc=%0d exp ch=%0d val=%0b cyc=%0d",
                                 res_ch_o, res_val_o, cyc, e.ch, e.val, e.cyc);
                    end
                end
            end

            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy_o === 1'b0) begin
                end_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        abort_i     = 1'b0;
        start_i     = 1'b0;
        res_ready_i = 1'b1;
        if (end_cyc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout got=busy exp=idle");
        end
    endtask

    task automatic check_tail(input string name, input int done_cnt, input int done_cyc,
                              input int end_cyc, input int exp_done, input int exp_end,
                              input logic [N_CH-1:0] exp_vec);
        n_cmp++;
        if (exp_done < 0 ? (done_cnt != 0) : (done_cnt != 1 || done_cyc != exp_done)) begin
            n_err++;
            $display("FAIL %s_done got cnt=%0d cyc=%0d exp cyc=%0d", name, done_cnt, done_cyc, exp_done);
        end
        n_cmp++;
        if (end_cyc != exp_end) begin
            n_err++;
            $display("FAIL %s_busy_drop got=%0d exp=%0d", name, end_cyc, exp_end);
        end
        n_cmp++;
        if (result_vec_o !== exp_vec) begin
            n_err++;
            $display("FAIL %s_result_vec got=%h exp=%h", name, result_vec_o, exp_vec);
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_results got=%0d exp=0", name, q.size());
        end
        q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if (valve_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || res_valid_o !== 1'b0 ||
            res_ch_o !== '0 || res_val_o !== 1'b0 || result_vec_o !== '0) begin
            n_err++;
            $display("FAIL %s got valve=%h busy=%b done=%b rv=%b ch=%0d val=%b vec=%h exp all zero",
                     name, valve_o, busy_o, done_o, res_valid_o, res_ch_o, res_val_o, result_vec_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; res_ready_i = 1'b1;
        disp_cycles_i = '0; mix_cycles_i = '0; det_in_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_nominal();
        int dc, dy, ec;
        push_results(4, 10, N_CH, 1'b1, -1, 0);
        run_seq(4, 10, -1, -1, 0, -1, -1, dc, dy, ec);
        check_tail("nominal", dc, dy, ec, 421, 422, 12'hFFF);
    endtask

    task automatic test_threshold(input int hi);
        int dc, dy, ec;
        logic v;
        v = (hi >= 8);
        push_results(4, 10, N_CH, v, -1, 0);
        run_seq(4, 10, hi, -1, 0, -1, -1, dc, dy, ec);
        check_tail(hi >= 8 ? "thresh_hi" : "thresh_lo", dc, dy, ec, 421, 422, {11'h7FF, v});
    endtask

    task automatic test_edge_timing();
        int dc, dy, ec;
        push_results(0, 0, N_CH, 1'b1, -1, 0);
        run_seq(0, 0, -1, -1, 0, -1, 100, dc, dy, ec);
        check_tail("edge", dc, dy, ec, 229, 230, 12'hFFF);
    endtask

    task automatic test_backpressure();
        int dc, dy, ec;
        push_results(4, 10, N_CH, 1'b1, 3, 5);
        run_seq(4, 10, -1, 3, 5, -1, -1, dc, dy, ec);
        check_tail("backpressure", dc, dy, ec, 426, 427, 12'hFFF);
    endtask

    task automatic test_abort();
        int dc, dy, ec;
        push_results(4, 10, 5, 1'b1, -1, 0);
        run_seq(4, 10, -1, -1, 0, 181, -1, dc, dy, ec);
        check_tail("abort", dc, dy, ec, -1, 182, 12'h01F);
        run_seq(4, 10, -1, -1, 0, 3, -1, dc, dy, ec);
        check_tail("abort_restart", dc, dy, ec, -1, 4, 12'h000);
    endtask

    task automatic test_reset_mid_mix();
        disp_cycles_i = 8'd4;
        mix_cycles_i  = 16'd10;
        det_in_i      = '1;
        res_ready_i   = 1'b1;
        start_i       = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        // Channel 1 mixes in cycles 44..53; reset sampled at the end of cycle 47.
        for (int cyc = 1; cyc < 47; cyc++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (busy_o !== 1'b1 || result_vec_o !== 12'h001) begin
            n_err++;
            $display("FAIL pre_reset_state got busy=%b vec=%h exp busy=1 vec=001", busy_o, result_vec_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("reset_mid_mix");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_threshold(8);
        test_threshold(7);
        test_edge_timing();
        test_backpressure();
        test_abort();
        test_reset_mid_mix();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
